// File: rtl/ktane_timer_pkg.sv
// Shared definitions for the KTANE countdown timer: FSM states, register
// offsets, the BCD count layout and the active-low seven-segment glyphs.
package ktane_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    // M:SS in BCD; minutes 0-9, tens 0-5, ones 0-9
    typedef struct packed {
        logic [3:0] min;
        logic [3:0] tens;
        logic [3:0] ones;
    } count_t;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFF10;

    localparam logic [15:0] OFF_LOAD   = 16'd0;
    localparam logic [15:0] OFF_CTRL   = 16'd1;
    localparam logic [15:0] OFF_STRIKE = 16'd2;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Clamp each BCD digit of a LOAD word to its legal range
    function automatic count_t load_saturate(input logic [11:0] raw);
        count_t c;
        c.min  = (raw[11:8] > 4'd9) ? 4'd9 : raw[11:8];
        c.tens = (raw[7:4]  > 4'd5) ? 4'd5 : raw[7:4];
        c.ones = (raw[3:0]  > 4'd9) ? 4'd9 : raw[3:0];
        return c;
    endfunction

    // One-second BCD decrement with borrow; caller guarantees c != 0:00
    function automatic count_t bcd_decrement(input count_t c);
        count_t r;
        r = c;
        if (c.ones != 4'd0) begin
            r.ones = c.ones - 4'd1;
        end else begin
            r.ones = 4'd9;
            if (c.tens != 4'd0) begin
                r.tens = c.tens - 4'd1;
            end else begin
                r.tens = 4'd5;
                r.min  = c.min - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ktane_timer_bcd_to_sevseg.sv
// BCD digit to active-low seven-segment glyph; non-decimal codes blank.
module bcd_to_sevseg
    import ktane_timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup of the glyph for one digit
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ktane_timer.sv
// Memory-mapped M:SS countdown timer with strike-accelerated ticking,
// registered read port and registered seven-segment digit outputs.
module ktane_timer
    import ktane_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    output logic [15:0] q,
    output logic [6:0]  timer_sevseg1,
    output logic [6:0]  timer_sevseg2,
    output logic [6:0]  timer_sevseg3,
    output logic        expired
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    state_t        state, state_next;
    count_t        count, count_ticked;
    logic [PW-1:0] presc, period_m1;
    logic [1:0]    strikes;
    logic          running;
    logic          sel_load, sel_ctrl, sel_strike;
    logic          load_wr, ctrl_wr, strike_wr, stop_wr, tick;
    logic [6:0]    seg_ones, seg_tens, seg_min;
    logic          unused_data;

    assign sel_load   = (addr == (BASE_ADDR + OFF_LOAD));
    assign sel_ctrl   = (addr == (BASE_ADDR + OFF_CTRL));
    assign sel_strike = (addr == (BASE_ADDR + OFF_STRIKE));

    assign load_wr   = we && sel_load;
    assign ctrl_wr   = we && sel_ctrl;
    assign strike_wr = we && sel_strike;
    assign stop_wr   = ctrl_wr && !data[0];

    // Upper data bits carry no register fields
    assign unused_data = ^data[15:12];

    // Each strike halves the period; comparing with >= makes a shortened
    // period take effect immediately when the prescaler is already past it.
    assign period_m1 = PW'(32'(CLK_HZ >> strikes) - 32'd1);

    // A LOAD or a stop request in the same cycle swallows the tick
    assign tick = running && (presc >= period_m1) && !load_wr && !stop_wr;

    // Saturate at 0:00 rather than wrapping
    assign count_ticked = (count == '0) ? count : bcd_decrement(count);

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // FSM next-state: CPU control writes and terminal tick
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_wr && data[0]) begin
                    state_next = (count == '0) ? ST_EXPIRED : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_wr) begin
                    state_next = ST_IDLE;
                end else if (tick && (count_ticked == '0)) begin
                    state_next = ST_EXPIRED;
                end
            end
            ST_EXPIRED: begin
                if (ctrl_wr && data[1]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        running = (state == ST_RUN);
        expired = (state == ST_EXPIRED);
    end

    // Count and prescaler: LOAD beats tick, tick beats counting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            presc <= '0;
        end else if (load_wr) begin
            count <= load_saturate(data[11:0]);
            presc <= '0;
        end else if (tick) begin
            count <= count_ticked;
            presc <= '0;
        end else if (running && !stop_wr) begin
            presc <= presc + PW'(1);
        end
    end

    // Strike register; code 3 collapses to 2
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            strikes <= 2'd0;
        end else if (strike_wr) begin
            strikes <= (data[1:0] == 2'd3) ? 2'd2 : data[1:0];
        end
    end

    // Registered read port, updated every cycle whatever we is
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= 16'h0000;
        end else if (sel_load || sel_ctrl) begin
            q <= {expired, running, strikes, count};
        end else if (sel_strike) begin
            q <= {14'd0, strikes};
        end else begin
            q <= 16'h0000;
        end
    end

    bcd_to_sevseg u_seg_ones (.bcd(count.ones), .seg(seg_ones));
    bcd_to_sevseg u_seg_tens (.bcd(count.tens), .seg(seg_tens));
    bcd_to_sevseg u_seg_min  (.bcd(count.min),  .seg(seg_min));

    // Display registers trail the count by one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_sevseg1 <= SEG_0;
            timer_sevseg2 <= SEG_0;
            timer_sevseg3 <= SEG_0;
        end else begin
            timer_sevseg1 <= seg_ones;
            timer_sevseg2 <= seg_tens;
            timer_sevseg3 <= seg_min;
        end
    end

endmodule

// File: tb/tb_ktane_timer.sv
// Self-checking bench for ktane_timer: a seconds-level behavioural model
// compared every cycle, plus directed literal checks.
module tb_ktane_timer;

    localparam int          CLK_HZ = 8;
    localparam logic [15:0] BASE   = 16'hFF10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] addr  = BASE;
    logic [15:0] data  = 16'h0000;
    logic [15:0] q;
    logic [6:0]  timer_sevseg1, timer_sevseg2, timer_sevseg3;
    logic        expired;
    logic [15:0] rd;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clock = ~clock;

    ktane_timer #(.CLK_HZ(CLK_HZ), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .we(we), .addr(addr), .data(data),
        .q(q), .timer_sevseg1(timer_sevseg1), .timer_sevseg2(timer_sevseg2),
        .timer_sevseg3(timer_sevseg3), .expired(expired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    // Model: time kept as whole seconds, mode as run/expired flags
    int          m_secs, m_phase, m_strikes;
    bit          m_run, m_exp;
    logic [15:0] m_q;
    logic [6:0]  m_s1, m_s2, m_s3;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_secs = 0; m_phase = 0; m_strikes = 0; m_run = 0; m_exp = 0;
            m_q = 16'h0000;
            m_s1 = glyph(0); m_s2 = glyph(0); m_s3 = glyph(0);
        end else begin
            bit wl, wc, ws, stop, fire, o_run, o_exp;
            int period, o_secs, mn, tn, on;
            wl = we && (addr == BASE);
            wc = we && (addr == BASE + 16'd1);
            ws = we && (addr == BASE + 16'd2);
            o_run = m_run; o_exp = m_exp; o_secs = m_secs;
            if (addr == BASE || addr == BASE + 16'd1)
                m_q = {m_exp, m_run, 2'(m_strikes), to_bcd(m_secs)};
            else if (addr == BASE + 16'd2)
                m_q = {14'd0, 2'(m_strikes)};
            else
                m_q = 16'h0000;
            m_s1 = glyph(m_secs % 10);
            m_s2 = glyph((m_secs % 60) / 10);
            m_s3 = glyph(m_secs / 60);
            period = CLK_HZ >> m_strikes;
            stop = wc && !data[0];
            fire = m_run && (m_phase >= period - 1) && !wl && !stop;
            if (wl) begin
                mn = (data[11:8] > 9) ? 9 : int'(data[11:8]);
                tn = (data[7:4]  > 5) ? 5 : int'(data[7:4]);
                on = (data[3:0]  > 9) ? 9 : int'(data[3:0]);
                m_secs = mn * 60 + tn * 10 + on;
                m_phase = 0;
            end else if (fire) begin
                m_phase = 0;
                if (m_secs > 0) m_secs--;
                if (m_secs == 0) begin m_run = 0; m_exp = 1; end
            end else if (m_run && !stop) begin
                m_phase++;
            end
            if (wc) begin
                if (o_run && !data[0]) m_run = 0;
                else if (o_exp && data[1]) m_exp = 0;
                else if (!o_run && !o_exp && data[0]) begin
                    if (o_secs == 0) m_exp = 1; else m_run = 1;
                end
            end
            if (ws) m_strikes = (data[1:0] == 2'd3) ? 2 : int'(data[1:0]);
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clock) begin
        if (cmp_en) begin
            check("model_q", q, m_q);
            check("model_expired", expired, m_exp);
            check("model_seg1", timer_sevseg1, m_s1);
            check("model_seg2", timer_sevseg2, m_s2);
            check("model_seg3", timer_sevseg3, m_s3);
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        we = 1'b1; addr = a; data = d;
        @(posedge clock); #2;
        we = 1'b0; addr = BASE; data = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
        addr = a;
        @(posedge clock); #2;
        v = q;
        addr = BASE;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q"}, q, 16'h0000);
        check({tag, "_expired"}, expired, 1'b0);
        check({tag, "_seg1"}, timer_sevseg1, 7'b1000000);
        check({tag, "_seg2"}, timer_sevseg2, 7'b1000000);
        check({tag, "_seg3"}, timer_sevseg3, 7'b1000000);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #2;
        check_reset_outputs("por");
        reset = 1'b1;
        cmp_en = 1'b1;

        // 0:12 at 1 tick per 8 cycles
        bus_write(BASE, 16'h0012);
        bus_write(BASE + 16'd1, 16'h0001);
        cycles(9);
        check("first_tick_0_11", q[11:0], 12'h011);
        check("running_bit", q[14], 1'b1);
        cycles(86);
        check("expired_before_96", expired, 1'b0);
        cycles(1);
        check("expired_at_96", expired, 1'b1);
        cycles(1);
        check("expired_status", q, 16'h8000);

        // Clear with run also set, then run again from 0:00
        bus_write(BASE + 16'd1, 16'h0003);
        check("clear_expired", expired, 1'b0);
        cycles(1);
        check("clear_mode_bits", q[15:14], 2'b00);
        bus_write(BASE + 16'd1, 16'h0001);
        check("run_at_zero_expires", expired, 1'b1);
        bus_write(BASE + 16'd1, 16'h0002);
        check("clear_again", expired, 1'b0);

        // Borrow across tens and minutes, then stop and hold
        bus_write(BASE, 16'h0100);
        bus_write(BASE + 16'd1, 16'h0001);
        cycles(9);
        check("borrow_0_59", q[11:0], 12'h059);
        check("seg2_five", timer_sevseg2, 7'b0010010);
        check("seg1_nine", timer_sevseg1, 7'b0010000);
        check("seg3_zero", timer_sevseg3, 7'b1000000);
        bus_write(BASE + 16'd1, 16'h0000);
        cycles(20);
        check("stopped_holds", q, 16'h0059);

        // Saturating load
        bus_write(BASE, 16'h0FFF);
        cycles(1);
        check("load_saturates", q[11:0], 12'h959);
        check("seg3_nine", timer_sevseg3, 7'b0010000);

        // Outside the window: writes ignored, reads zero
        bus_write(BASE + 16'd3, 16'h0123);
        bus_read(BASE + 16'd3, rd);
        check("oow_read_hi", rd, 16'h0000);
        bus_read(BASE - 16'd1, rd);
        check("oow_read_lo", rd, 16'h0000);
        bus_read(BASE + 16'd1, rd);
        check("ctrl_alias_read", rd, 16'h0959);

        // Two strikes: 0:03 expires after 6 cycles
        bus_write(BASE + 16'd2, 16'h0002);
        bus_write(BASE, 16'h0003);
        bus_write(BASE + 16'd1, 16'h0001);
        cycles(5);
        check("strike2_not_yet", expired, 1'b0);
        cycles(1);
        check("strike2_expired", expired, 1'b1);
        bus_write(BASE + 16'd1, 16'h0002);
        bus_write(BASE + 16'd2, 16'h0003);
        bus_read(BASE + 16'd2, rd);
        check("strike3_reads_2", rd, 16'h0002);
        bus_write(BASE + 16'd2, 16'h0000);

        // Strike raised mid-period: prescaler already past new period
        bus_write(BASE, 16'h0005);
        bus_write(BASE + 16'd1, 16'h0001);
        cycles(3);
        bus_write(BASE + 16'd2, 16'h0002);
        cycles(2);
        check("strike_change_tick", q, 16'h6004);
        // LOAD lands on a tick cycle and wins
        bus_write(BASE, 16'h0030);
        cycles(1);
        check("load_beats_tick", q[11:0], 12'h030);
        cycles(2);
        check("tick_after_load", q[11:0], 12'h029);
        bus_write(BASE + 16'd1, 16'h0000);
        bus_write(BASE + 16'd2, 16'h0000);

        // Reset in the middle of a run at 0:40
        bus_write(BASE, 16'h0040);
        bus_write(BASE + 16'd1, 16'h0001);
        cycles(5);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrun");
        cycles(2);
        reset = 1'b1;
        cycles(100);
        check("no_tick_after_reset", q, 16'h0000);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
